// File: rtl/dpm_group_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : dpm_group_engine_if
//  Purpose  : Bundles the job-control, show-ahead FIFO and valid/ready result
//             signals of dpm_group_engine into one interface.
//  Modports : master - job controller / FIFO / downstream side (drives start,
//                      num_groups, bypass_mode, fifo_data, fifo_data_valid,
//                      out_ready)
//             slave  - the engine itself (drives fifo_pop, out_data,
//                      out_valid, group_idx, busy, done)
//  Revision : 1.0 - initial release
// ============================================================================
interface dpm_group_engine_if #(
   parameter int DATA_W     = 16,
   parameter int N_CH       = 36,
   parameter int GROUP_ROWS = 4
);
   localparam int ACC_W = DATA_W + $clog2(GROUP_ROWS);
   localparam int CNT_W = $clog2(N_CH + 1);

   logic              start;
   logic [CNT_W-1:0]  num_groups;
   logic              bypass_mode;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_data_valid;
   logic              fifo_pop;
   logic [ACC_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  group_idx;
   logic              busy;
   logic              done;

   modport master (
      output start, num_groups, bypass_mode, fifo_data, fifo_data_valid, out_ready,
      input  fifo_pop, out_data, out_valid, group_idx, busy, done
   );

   modport slave (
      input  start, num_groups, bypass_mode, fifo_data, fifo_data_valid, out_ready,
      output fifo_pop, out_data, out_valid, group_idx, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/dpm_group_engine.sv
`default_nettype none
// ============================================================================
//  Module   : dpm_group_engine
//  Purpose  : Pops GROUP_ROWS words per group from a show-ahead FIFO, sums
//             them, waits PROC_LAT cycles and emits one result per group on a
//             valid/ready output, for a programmable number of groups per job.
//             Bypass mode streams raw FIFO words to the output instead.
//  Ports    : clk  - clock
//             rst  - asynchronous active-high reset
//             bus  - dpm_group_engine_if.slave (start, num_groups, bypass_mode,
//                    fifo_data, fifo_data_valid, fifo_pop, out_data, out_valid,
//                    out_ready, group_idx, busy, done)
//  Revision : 1.0 - initial release
// ============================================================================
module dpm_group_engine #(
   parameter int DATA_W     = 16,
   parameter int N_CH       = 36,
   parameter int GROUP_ROWS = 4,
   parameter int PROC_LAT   = 3
) (
   input  logic               clk,
   input  logic               rst,
   dpm_group_engine_if.slave  bus
);
   localparam int ACC_W = DATA_W + $clog2(GROUP_ROWS);
   localparam int CNT_W = $clog2(N_CH + 1);
   localparam int ROW_W = (GROUP_ROWS > 1) ? $clog2(GROUP_ROWS) : 1;
   localparam int LAT_W = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;
   localparam int WRD_W = $clog2(N_CH * GROUP_ROWS + 1);

   localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(GROUP_ROWS - 1);
   localparam logic [LAT_W-1:0] c_LAT_LOAD = LAT_W'(PROC_LAT - 1);
   localparam logic [CNT_W-1:0] c_N_CH     = CNT_W'(N_CH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_PROCESS = 3'd2,
      S_OUTPUT  = 3'd3,
      S_BYPASS  = 3'd4
   } state_t;

   state_t            state_q,     state_d;
   logic [ACC_W-1:0]  acc_q,       acc_d;
   logic [ROW_W-1:0]  row_q,       row_d;
   logic [LAT_W-1:0]  lat_q,       lat_d;
   logic [CNT_W-1:0]  ngrp_q,      ngrp_d;
   logic [CNT_W-1:0]  grp_q,       grp_d;
   logic [WRD_W-1:0]  wtot_q,      wtot_d;
   logic [WRD_W-1:0]  wpop_q,      wpop_d;
   logic [ACC_W-1:0]  out_data_q,  out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              done_q,      done_d;

   logic              w_pop;
   logic              w_accept;
   logic              w_last_grp;
   logic [CNT_W-1:0]  w_ng_clamp;

   assign w_accept   = out_valid_q & bus.out_ready;
   assign w_last_grp = (grp_q == ngrp_q - CNT_W'(1));
   assign w_ng_clamp = (bus.num_groups > c_N_CH) ? c_N_CH : bus.num_groups;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      row_d       = row_q;
      lat_d       = lat_q;
      ngrp_d      = ngrp_q;
      grp_d       = grp_q;
      wtot_d      = wtot_q;
      wpop_d      = wpop_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      w_pop       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (w_ng_clamp == '0) begin
                  done_d = 1'b1;
               end else begin
                  ngrp_d  = w_ng_clamp;
                  wtot_d  = WRD_W'(w_ng_clamp) * WRD_W'(GROUP_ROWS);
                  wpop_d  = '0;
                  acc_d   = '0;
                  row_d   = '0;
                  grp_d   = '0;
                  state_d = bus.bypass_mode ? S_BYPASS : S_READ;
               end
            end
         end

         S_READ: begin
            if (bus.fifo_data_valid) begin
               w_pop = 1'b1;
               acc_d = acc_q + ACC_W'(bus.fifo_data);
               if (row_q == c_ROW_LAST) begin
                  row_d   = '0;
                  lat_d   = c_LAT_LOAD;
                  state_d = S_PROCESS;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end
         end

         // Counter is loaded with PROC_LAT-1 so the state lasts PROC_LAT cycles.
         S_PROCESS: begin
            if (lat_q == '0) begin
               out_data_d  = acc_q;
               out_valid_d = 1'b1;
               state_d     = S_OUTPUT;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end

         S_OUTPUT: begin
            if (w_accept) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               row_d       = '0;
               if (w_last_grp) begin
                  done_d  = 1'b1;
                  grp_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  grp_d   = grp_q + CNT_W'(1);
                  state_d = S_READ;
               end
            end
         end

         // row_q counts accepted words within a group; wpop_q stops popping
         // once the whole job has been pulled from the FIFO, so the final
         // accept always leaves the output register empty.
         S_BYPASS: begin
            w_pop = bus.fifo_data_valid && (!out_valid_q || bus.out_ready) &&
                    (wpop_q != wtot_q);
            if (w_accept) begin
               out_valid_d = 1'b0;
               if (row_q == c_ROW_LAST) begin
                  row_d = '0;
                  if (w_last_grp) begin
                     done_d  = 1'b1;
                     grp_d   = '0;
                     state_d = S_IDLE;
                  end else begin
                     grp_d = grp_q + CNT_W'(1);
                  end
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end
            if (w_pop) begin
               out_data_d  = ACC_W'(bus.fifo_data);
               out_valid_d = 1'b1;
               wpop_d      = wpop_q + WRD_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         row_q       <= '0;
         lat_q       <= '0;
         ngrp_q      <= '0;
         grp_q       <= '0;
         wtot_q      <= '0;
         wpop_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         row_q       <= row_d;
         lat_q       <= lat_d;
         ngrp_q      <= ngrp_d;
         grp_q       <= grp_d;
         wtot_q      <= wtot_d;
         wpop_q      <= wpop_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign bus.fifo_pop  = w_pop;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.group_idx = grp_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dpm_group_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dpm_group_engine
//  Purpose  : Self-checking bench for dpm_group_engine. A queue-based model of
//             the FIFO contents and of the expected result stream is checked
//             against the DUT on every clock; directed jobs pin the model with
//             literal sums and latencies, random jobs exercise both modes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dpm_group_engine;
   localparam int DATA_W = 16;
   localparam int N_CH   = 36;
   localparam int GR     = 4;
   localparam int PL     = 3;
   localparam int ACC_W  = DATA_W + $clog2(GR);
   localparam int CNT_W  = $clog2(N_CH + 1);

   logic clk;
   logic rst;

   dpm_group_engine_if #(.DATA_W(DATA_W), .N_CH(N_CH), .GROUP_ROWS(GR)) bus ();

   dpm_group_engine #(.DATA_W(DATA_W), .N_CH(N_CH), .GROUP_ROWS(GR), .PROC_LAT(PL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(input bit ok, input string nm,
                               input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
   endfunction

   // ---------------- FIFO / downstream environment ----------------
   logic [DATA_W-1:0] fq[$];      // FIFO contents, head at index 0
   logic [ACC_W-1:0]  exp_q[$];   // expected accepted outputs, in order
   int  stall_n   = 0;            // directed cycles of forced-empty FIFO
   bit  rnd_stall = 1'b0;
   int  rdy_mode  = 0;            // 0: ready=1, 1: random, 2: toggle, 3: held low
   bit  en;

   always @(posedge clk) begin
      #1;
      if (stall_n > 0) begin
         stall_n = stall_n - 1;
         en      = 1'b0;
      end else begin
         en = !(rnd_stall && ($urandom_range(0, 3) == 0));
      end
      bus.fifo_data_valid = en && (fq.size() > 0);
      bus.fifo_data       = (fq.size() > 0) ? fq[0] : '0;
      case (rdy_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'($urandom_range(0, 1));
         2:       bus.out_ready = !bus.out_ready;
         default: bus.out_ready = 1'b0;
      endcase
   end

   // ---------------- reference model + compare process ----------------
   int  cyc          = 0;
   bit  m_busy       = 1'b0;
   bit  m_done_nxt   = 1'b0;
   bit  m_bypass     = 1'b0;
   int  m_total      = 0;     // outputs expected in the job
   int  m_words      = 0;     // words the job must pop
   int  m_acc_cnt    = 0;
   int  m_pop_cnt    = 0;
   int  total_pops   = 0;
   int  jobs_done    = 0;
   int  last_pop_cyc = -100;
   int  first_pop[64];
   int  rise_cyc[64];
   bit  prev_valid   = 1'b0;
   bit  prev_hold    = 1'b0;
   logic [ACC_W-1:0] prev_data;
   logic [CNT_W-1:0] prev_gidx;
   bit  nb, nd;
   int  ng;
   logic [ACC_W-1:0] e;

   always @(negedge clk) begin
      if (rst) begin
         chk(bus.fifo_pop === 1'b0, "pop_during_rst", bus.fifo_pop, 0);
         m_busy = 0; m_done_nxt = 0; m_acc_cnt = 0; m_pop_cnt = 0;
         prev_valid = 0; prev_hold = 0; last_pop_cyc = -100;
         exp_q.delete();
      end else begin
         cyc++;
         nb = m_busy;
         nd = 1'b0;
         chk(bus.busy === m_busy, "busy", bus.busy, m_busy);
         chk(bus.done === m_done_nxt, "done", bus.done, m_done_nxt);
         if (bus.done === 1'b1) jobs_done++;

         if (bus.fifo_pop === 1'b1) begin
            chk(bus.fifo_data_valid && m_busy && (m_bypass || !bus.out_valid) &&
                (m_pop_cnt < m_words), "pop_legal", m_pop_cnt, m_words);
            if (fq.size() > 0) void'(fq.pop_front());
            if (m_pop_cnt % GR == 0 && m_pop_cnt / GR < 64) first_pop[m_pop_cnt / GR] = cyc;
            m_pop_cnt++;
            total_pops++;
            if (m_pop_cnt % GR == 0) last_pop_cyc = cyc;
         end

         if (prev_hold)
            chk(bus.out_valid === 1'b1 && bus.out_data === prev_data && bus.group_idx === prev_gidx,
                "hold_stable", {bus.out_valid, bus.out_data}, {1'b1, prev_data});

         if (bus.out_valid && !prev_valid && !m_bypass && m_busy) begin
            chk(cyc - last_pop_cyc == PL + 1, "result_latency", cyc - last_pop_cyc, PL + 1);
            if (m_acc_cnt < 64) rise_cyc[m_acc_cnt] = cyc;
         end

         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_output", bus.out_data, 0);
            end else begin
               e = exp_q.pop_front();
               chk(bus.out_data === e, "out_data", bus.out_data, e);
            end
            chk(int'(bus.group_idx) == m_acc_cnt / (m_bypass ? GR : 1), "group_idx",
                bus.group_idx, m_acc_cnt / (m_bypass ? GR : 1));
            m_acc_cnt++;
            if (m_acc_cnt == m_total) begin
               chk(m_pop_cnt == m_words, "job_pop_count", m_pop_cnt, m_words);
               nb = 1'b0;
               nd = 1'b1;
            end
         end

         if (bus.start && !m_busy) begin
            ng = (int'(bus.num_groups) > N_CH) ? N_CH : int'(bus.num_groups);
            if (ng == 0) begin
               nd = 1'b1;
            end else begin
               nb        = 1'b1;
               m_bypass  = bus.bypass_mode;
               m_total   = bus.bypass_mode ? ng * GR : ng;
               m_words   = ng * GR;
               m_acc_cnt = 0;
               m_pop_cnt = 0;
            end
         end

         prev_valid = bus.out_valid;
         prev_hold  = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_gidx  = bus.group_idx;
         m_busy     = nb;
         m_done_nxt = nd;
      end
   end

   // ---------------- stimulus helpers ----------------
   int job_target = 0;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic load_words(input int groups, input bit byp);
      logic [DATA_W-1:0] w;
      logic [ACC_W-1:0]  s;
      for (int g = 0; g < groups; g++) begin
         s = '0;
         for (int r = 0; r < GR; r++) begin
            w = DATA_W'($urandom);
            fq.push_back(w);
            s = s + ACC_W'(w);
            if (byp) exp_q.push_back(ACC_W'(w));
         end
         if (!byp) exp_q.push_back(s);
      end
   endtask

   task automatic start_job(input int ngr, input bit byp);
      job_target      = jobs_done + 1;
      bus.num_groups  = CNT_W'(ngr);
      bus.bypass_mode = byp;
      bus.start       = 1'b1;
      step();
      bus.start       = 1'b0;
      bus.num_groups  = CNT_W'($urandom);
      bus.bypass_mode = 1'($urandom);
   endtask

   task automatic finish_job(input int budget);
      int n = 0;
      while (jobs_done < job_target && n < budget) begin
         step();
         n++;
      end
      chk(jobs_done >= job_target, "job_done_timeout", jobs_done, job_target);
      step();
      chk(exp_q.size() == 0, "results_drained", exp_q.size(), 0);
      chk(fq.size() == 0, "fifo_drained", fq.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   int p0;
   int n;
   logic [ACC_W-1:0] d0;
   logic [CNT_W-1:0] g0;

   initial begin
      rst                 = 1'b1;
      bus.start           = 1'b0;
      bus.num_groups      = '0;
      bus.bypass_mode     = 1'b0;
      bus.fifo_data       = '0;
      bus.fifo_data_valid = 1'b0;
      bus.out_ready       = 1'b1;
      repeat (3) step();
      chk(bus.out_data === '0 && bus.out_valid === 1'b0 && bus.group_idx === '0 &&
          bus.done === 1'b0 && bus.busy === 1'b0 && bus.fifo_pop === 1'b0,
          "reset_values", {bus.out_valid, bus.busy, bus.done, bus.fifo_pop}, 0);
      rst = 1'b0;
      step();

      // Directed job: words 1..8 give sums 10 and 26
      for (int i = 1; i <= 8; i++) fq.push_back(DATA_W'(i));
      exp_q.push_back(ACC_W'(10));
      exp_q.push_back(ACC_W'(26));
      p0 = total_pops;
      start_job(2, 1'b0);
      finish_job(300);
      chk(rise_cyc[0] - first_pop[0] == 7, "t1_latency_g0", rise_cyc[0] - first_pop[0], 7);
      chk(rise_cyc[1] - first_pop[1] == 7, "t1_latency_g1", rise_cyc[1] - first_pop[1], 7);
      chk(first_pop[1] - first_pop[0] == 8, "t1_group_spacing", first_pop[1] - first_pop[0], 8);
      chk(total_pops - p0 == 8, "t1_pops", total_pops - p0, 8);

      // Same job with a 3-cycle FIFO gap mid group 0
      for (int i = 1; i <= 8; i++) fq.push_back(DATA_W'(i));
      exp_q.push_back(ACC_W'(10));
      exp_q.push_back(ACC_W'(26));
      start_job(2, 1'b0);
      n = 0;
      while (m_pop_cnt < 2 && n < 50) begin step(); n++; end
      stall_n = 3;
      finish_job(300);

      // Output backpressure held for 5 cycles
      load_words(2, 1'b0);
      rdy_mode = 3;
      start_job(2, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 100) begin step(); n++; end
      chk(bus.out_valid === 1'b1, "t3_valid_seen", bus.out_valid, 1);
      d0 = bus.out_data;
      g0 = bus.group_idx;
      p0 = total_pops;
      repeat (5) step();
      chk(bus.out_valid === 1'b1 && bus.out_data === d0 && bus.group_idx === g0 && total_pops == p0,
          "t3_held", bus.out_data, d0);
      rdy_mode = 0;
      finish_job(300);

      // Bypass with toggling ready
      fq.push_back(16'hFFFF); fq.push_back(16'd1); fq.push_back(16'd2); fq.push_back(16'd3);
      exp_q.push_back(ACC_W'(16'hFFFF)); exp_q.push_back(ACC_W'(1));
      exp_q.push_back(ACC_W'(2));        exp_q.push_back(ACC_W'(3));
      rdy_mode = 2;
      p0 = total_pops;
      start_job(1, 1'b1);
      finish_job(300);
      chk(total_pops - p0 == 4, "t4_pops", total_pops - p0, 4);
      rdy_mode = 0;

      // Zero groups, then clamping of 40 to 36
      p0 = total_pops;
      start_job(0, 1'b0);
      finish_job(20);
      chk(total_pops == p0, "t5_no_pops", total_pops - p0, 0);
      load_words(N_CH, 1'b0);
      rdy_mode  = 1;
      rnd_stall = 1'b1;
      start_job(40, 1'b0);
      finish_job(6000);
      chk(m_acc_cnt == 36, "t5_clamp_groups", m_acc_cnt, 36);
      rdy_mode  = 0;
      rnd_stall = 1'b0;

      // Reset during PROCESS of group 1
      load_words(3, 1'b0);
      start_job(3, 1'b0);
      n = 0;
      while (m_pop_cnt < 8 && n < 100) begin step(); n++; end
      #1 rst = 1'b1;
      #1;
      chk(bus.out_data === '0 && bus.out_valid === 1'b0 && bus.group_idx === '0 &&
          bus.done === 1'b0 && bus.busy === 1'b0 && bus.fifo_pop === 1'b0,
          "t6_async_reset", {bus.out_data, bus.group_idx, bus.busy}, 0);
      repeat (2) step();
      fq.delete();
      rst = 1'b0;
      step();
      load_words(4, 1'b0);
      start_job(4, 1'b0);
      repeat (3) step();
      bus.num_groups  = CNT_W'(1);
      bus.bypass_mode = 1'b1;
      bus.start       = 1'b1;
      step();
      bus.start       = 1'b0;
      finish_job(400);

      // Randomized jobs in both modes
      for (int j = 0; j < 8; j++) begin
         int  rng;
         bit  rbyp;
         rng       = $urandom_range(1, 6);
         rbyp      = 1'($urandom_range(0, 1));
         rdy_mode  = $urandom_range(0, 2);
         rnd_stall = 1'($urandom_range(0, 1));
         load_words(rng, rbyp);
         start_job(rng, rbyp);
         finish_job(200 + rng * 120);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
